// File: rtl/fft_fifo_interface.sv
// Bus-readable sample FIFO between an FFT streaming source and a memory-mapped slave port.
// Registers: 0 DATA (pop), 1 STATUS, 2 CONTROL, 3 DROPS; read data is registered.
module fft_fifo_interface #(
   parameter int unsigned DATA_SIZE   = 28,
   parameter int unsigned DEPTH       = 16,
   parameter bit          SIGN_EXTEND = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 chipselect,
   input  logic [1:0]           address,
   input  logic                 read,
   input  logic                 write,
   input  logic [31:0]          writedata,
   output logic [31:0]          read_data,
   input  logic                 source_valid,
   input  logic [DATA_SIZE-1:0] source_data,
   output logic                 source_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FullCount = CW'(DEPTH);

   logic [DATA_SIZE-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]        count_q, count_d;
   logic                 enable_q, enable_d, underflow_q, underflow_d;
   logic [15:0]          drop_count_q, drop_count_d;
   logic [31:0]          read_data_q, read_data_d;

   logic full, empty, push, drop, bus_rd, bus_wr, pop, ctrl_wr, flush, clear;
   logic [DATA_SIZE-1:0] head;
   logic [31:0]          head_ext, status_word;

   assign full         = (count_q == FullCount);
   assign empty        = (count_q == '0);
   assign source_ready = enable_q & ~full;
   assign push         = source_valid & source_ready;
   assign drop         = source_valid & ~source_ready;

   // A read strobe wins over a simultaneous write strobe.
   assign bus_rd  = chipselect & read;
   assign bus_wr  = chipselect & write & ~read;
   assign pop     = bus_rd & (address == 2'd0) & ~empty;
   assign ctrl_wr = bus_wr & (address == 2'd2);
   assign flush   = ctrl_wr & writedata[1];
   assign clear   = ctrl_wr & writedata[2];

   assign head = mem_q[rd_ptr_q];

   if (SIGN_EXTEND) begin : g_sext
      assign head_ext = 32'($signed(head));
   end else begin : g_zext
      assign head_ext = 32'(head);
   end

   assign status_word = {16'(count_q), 12'b0, underflow_q, |drop_count_q, full, empty};

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      enable_d     = enable_q;
      underflow_d  = underflow_q;
      drop_count_d = drop_count_q;
      read_data_d  = read_data_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (ctrl_wr) enable_d = writedata[0];

      if (clear) begin
         drop_count_d = '0;
         underflow_d  = 1'b0;
      end else begin
         if (drop && (drop_count_q != 16'hFFFF)) drop_count_d = drop_count_q + 16'd1;
         if (bus_rd && (address == 2'd0) && empty) underflow_d = 1'b1;
      end

      if (bus_rd) begin
         unique case (address)
            2'd0:    read_data_d = empty ? 32'd0 : head_ext;
            2'd1:    read_data_d = status_word;
            2'd2:    read_data_d = {31'b0, enable_q};
            default: read_data_d = {16'b0, drop_count_q};
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         enable_q     <= 1'b1;
         underflow_q  <= 1'b0;
         drop_count_q <= '0;
         read_data_q  <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         enable_q     <= enable_d;
         underflow_q  <= underflow_d;
         drop_count_q <= drop_count_d;
         read_data_q  <= read_data_d;
      end
   end

   // Storage has no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (!reset && push && !flush) mem_q[wr_ptr_q] <= source_data;
   end

   assign read_data = read_data_q;

endmodule

// File: doc/fft_fifo_interface.md
FFT_FIFO_INTERFACE -- requirements
Module: fft_fifo_interface

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 28, meaning sample width in bits, legal range 1..32.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries, power of two, legal range 2..256.
REQ-003 SHALL have parameter SIGN_EXTEND, default 0, meaning 1 = sign-extend data to 32 bits and 0 = zero-extend.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single 50 MHz clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, meaning synchronous active-high reset.
REQ-006 SHALL have port chipselect, input, 1 bit, meaning bus slave select.
REQ-007 SHALL have port address, input, 2 bits, meaning register select (0 DATA, 1 STATUS, 2 CONTROL, 3 DROPS).
REQ-008 SHALL have port read, input, 1 bit, meaning bus read strobe.
REQ-009 SHALL have port write, input, 1 bit, meaning bus write strobe.
REQ-010 SHALL have port writedata, input, 32 bits, meaning bus write data.
REQ-011 SHALL have port read_data, output, 32 bits, meaning registered bus read data.
REQ-012 SHALL have port source_valid, input, 1 bit, meaning FFT sample valid.
REQ-013 SHALL have port source_data, input, DATA_SIZE bits, meaning FFT sample.
REQ-014 SHALL have port source_ready, output, 1 bit, meaning the block will accept a sample this cycle.

Function
REQ-015 SHALL buffer samples in a DEPTH-entry circular FIFO with wrapping read and write pointers and a count of width $clog2(DEPTH)+1.
REQ-016 SHALL drive source_ready = enable AND NOT full, derived combinationally from registered state.
REQ-017 SHALL push source_data when source_valid and source_ready are both high, accepting the sample in that cycle.
REQ-018 SHALL treat source_valid while source_ready is low as a drop: the sample is discarded and the saturating 16-bit drop counter is incremented, holding at 0xFFFF.
REQ-019 SHALL pop on chipselect & read & address==0 & !empty, loading read_data with the extended head entry on the same edge (1-cycle read latency).
REQ-020 SHALL, on a DATA read while empty, load read_data with 0, perform no pop, and set the sticky underflow flag.
REQ-021 SHALL, on a STATUS read, load read_data with {count in [31:16], zeros, underflow [3], drop-nonzero [2], full [1], empty [0]}.
REQ-022 SHALL, on a CONTROL read, load read_data with {zeros, enable [0]}.
REQ-023 SHALL, on a DROPS read, load read_data with {16'b0, drop_count}.
REQ-024 SHALL hold read_data at its last value when no read is decoded.
REQ-025 SHALL, on a write to CONTROL, take enable = writedata[0].
REQ-026 SHALL, on a write to CONTROL with writedata[1]=1, flush the FIFO (pointers and count to 0) in that cycle.
REQ-027 SHALL, on a write to CONTROL with writedata[2]=1, clear the drop counter and the underflow flag.
REQ-028 SHALL ignore writes to addresses 0, 1 and 3.
REQ-029 SHALL, on a simultaneous push and pop, perform both with count unchanged; when full, push eligibility is judged on start-of-cycle state, so a push in that cycle is a drop even with a concurrent pop.
REQ-030 SHALL give flush priority over a same-cycle push and pop, discarding both; a drop in the flush cycle is still counted unless a clear is also written.
REQ-031 SHALL ignore read and write unless chipselect is high, and SHALL perform the read when read and write are asserted together.

Reset
REQ-032 SHALL, on reset, set FIFO pointers and count to 0, set enable=1, clear drop_count and the underflow flag, and set read_data=0.
REQ-033 SHALL, for reset asserted mid-operation, give reset priority over all other events, discarding FIFO contents; source_ready SHALL be 1 in the first cycle after reset.
REQ-034 SHALL leave FIFO storage contents uninitialised by reset; they are not observable.

Verification
REQ-035 SHALL pass this scenario: push 0x0000123, 0x0ABCDEF, then DATA read twice -> read_data 0x00000123 then 0x00ABCDEF one cycle after each read; STATUS read returns 0x00000001.
REQ-036 SHALL pass this scenario: with DEPTH=16, stream 20 valid samples with no reads -> source_ready low after the 16th; STATUS=0x00100006; DROPS=0x00000004.
REQ-037 SHALL pass this scenario: with SIGN_EXTEND=1, push 0x8000000 -> DATA read returns 0xF8000000; with SIGN_EXTEND=0 it returns 0x08000000.
REQ-038 SHALL pass this scenario: DATA read while empty -> read_data 0, STATUS bit3=1; then write CONTROL 0x5 -> STATUS 0x00000001, DROPS 0.
REQ-039 SHALL pass this scenario: FIFO full, DATA read with concurrent source_valid -> one pop, drop_count +1, count 15; next cycle push accepted, count 16.
REQ-040 SHALL pass this scenario: write CONTROL 0x3 with 5 entries -> count 0, empty=1, enable=1; write CONTROL 0x0 -> source_ready=0 and every valid sample increments DROPS.
